// File: rtl/ahb_pkg.sv
// AHB shared encodings, arbiter state type
// and burst-length helper.
package ahb_pkg;

   localparam logic [1:0] HT_IDLE   = 2'b00;
   localparam logic [1:0] HT_BUSY   = 2'b01;
   localparam logic [1:0] HT_NONSEQ = 2'b10;
   localparam logic [1:0] HT_SEQ    = 2'b11;

   localparam logic [2:0] HB_SINGLE = 3'd0;
   localparam logic [2:0] HB_INCR   = 3'd1;
   localparam logic [2:0] HB_WRAP4  = 3'd2;
   localparam logic [2:0] HB_INCR4  = 3'd3;
   localparam logic [2:0] HB_WRAP8  = 3'd4;
   localparam logic [2:0] HB_INCR8  = 3'd5;
   localparam logic [2:0] HB_WRAP16 = 3'd6;
   localparam logic [2:0] HB_INCR16 = 3'd7;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_OWNED,
      ARB_LOCKED
   } arb_state_t;

   // Beats remaining after the NONSEQ beat.
   function automatic logic [4:0] burst_len(
      input logic [2:0] hburst
   );
      logic [4:0] len;
      len = 5'd0;
      unique case (hburst)
         HB_WRAP4,  HB_INCR4:  len = 5'd3;
         HB_WRAP8,  HB_INCR8:  len = 5'd7;
         HB_WRAP16, HB_INCR16: len = 5'd15;
         default:              len = 5'd0;
      endcase
      return len;
   endfunction

   function automatic logic is_fixed(
      input logic [2:0] hburst
   );
      return hburst[2] | hburst[1];
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first
// requester at or after ptr wins, one-hot.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   logic         found;
   logic [N-1:0] sel;
   int           j;

   // Walk the ring from ptr, take first request.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      sel   = '0;
      j     = 0;
      for (int i = 0; i < N; i++) begin
         j   = (int'(ptr) + i) % N;
         sel = {{(N-1){1'b0}}, 1'b1} << j;
         if (!found && |(req & sel)) begin
            gnt   = sel;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB multi-master arbiter with address/data
// muxing toward the ahb2apb bridge.
module ahb_arbiter
   import ahb_pkg::*;
#(
   parameter int NUM_MST      = 2,
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int HBURST_WIDTH = 3
) (
   input  logic                           hclk_i,
   input  logic                           hrst_i,
   input  logic [NUM_MST-1:0]             hbusreq_i,
   input  logic [NUM_MST-1:0]             hlock_i,
   input  logic [NUM_MST*ADDR_WIDTH-1:0]  haddr_m_i,
   input  logic [NUM_MST*2-1:0]           htrans_m_i,
   input  logic [NUM_MST*HBURST_WIDTH-1:0] hburst_m_i,
   input  logic [NUM_MST*3-1:0]           hsize_m_i,
   input  logic [NUM_MST-1:0]             hwrite_m_i,
   input  logic [NUM_MST*DATA_WIDTH-1:0]  hwdata_m_i,
   input  logic                           hready_i,
   output logic [NUM_MST-1:0]             hgrant_o,
   output logic [$clog2(NUM_MST)-1:0]     hmaster_o,
   output logic                           hmastlock_o,
   output logic [ADDR_WIDTH-1:0]          haddr_o,
   output logic [1:0]                     htrans_o,
   output logic [HBURST_WIDTH-1:0]        hburst_o,
   output logic [2:0]                     hsize_o,
   output logic                           hwrite_o,
   output logic [DATA_WIDTH-1:0]          hwdata_o
);

   localparam int MW = $clog2(NUM_MST);
   localparam logic [NUM_MST-1:0] PARK =
      {{(NUM_MST-1){1'b0}}, 1'b1};

   logic [ADDR_WIDTH-1:0]   addr_a  [NUM_MST];
   logic [1:0]              trans_a [NUM_MST];
   logic [HBURST_WIDTH-1:0] burst_a [NUM_MST];
   logic [2:0]              size_a  [NUM_MST];
   logic [DATA_WIDTH-1:0]   wdata_a [NUM_MST];

   arb_state_t              state, state_nxt;
   logic [NUM_MST-1:0]      grant_nxt, rr_gnt;
   logic [MW-1:0]           master_nxt, gnt_idx;
   logic [MW-1:0]           ptr, downer;
   logic [4:0]              cnt, cnt_nxt;
   logic [1:0]              own_trans;
   logic [HBURST_WIDTH-1:0] own_burst;
   logic                    own_req, own_lock;
   logic                    fixed, boundary;
   logic                    handover;

   for (genvar k = 0; k < NUM_MST; k++) begin : g_unpack
      assign addr_a[k]  =
         haddr_m_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign trans_a[k] = htrans_m_i[k*2 +: 2];
      assign burst_a[k] =
         hburst_m_i[k*HBURST_WIDTH +: HBURST_WIDTH];
      assign size_a[k]  = hsize_m_i[k*3 +: 3];
      assign wdata_a[k] =
         hwdata_m_i[k*DATA_WIDTH +: DATA_WIDTH];
   end

   assign haddr_o     = addr_a[hmaster_o];
   assign htrans_o    = trans_a[hmaster_o];
   assign hburst_o    = burst_a[hmaster_o];
   assign hsize_o     = size_a[hmaster_o];
   assign hwrite_o    = hwrite_m_i[hmaster_o];
   assign hwdata_o    = wdata_a[downer];
   assign hmastlock_o = (state == ARB_LOCKED);

   assign own_trans = trans_a[hmaster_o];
   assign own_burst = burst_a[hmaster_o];
   assign own_req   = hbusreq_i[hmaster_o];
   assign own_lock  = hlock_i[hmaster_o];
   assign fixed     = is_fixed(own_burst[2:0]);

   // Grant has moved but the new owner has not
   // yet taken the address phase.
   assign handover = (gnt_idx != hmaster_o);

   // Last beat of a fixed burst is the one that
   // drives the beat counter to zero.
   assign boundary =
      (own_trans == HT_IDLE) ||
      (!fixed && !own_req) ||
      (fixed && own_trans[1] && cnt_nxt == 5'd0);

   assign ptr = (hmaster_o == MW'(NUM_MST - 1)) ?
                '0 : hmaster_o + 1'b1;

   rr_arbiter #(
      .N  (NUM_MST),
      .PW (MW)
   ) u_rr (
      .req (hbusreq_i),
      .ptr (ptr),
      .gnt (rr_gnt)
   );

   // One-hot grant to index.
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         if (hgrant_o[i]) gnt_idx = MW'(i);
      end
   end

   // Beat counter: load on NONSEQ, count SEQ.
   always_comb begin
      cnt_nxt = cnt;
      if (hready_i) begin
         if (own_trans == HT_NONSEQ)
            cnt_nxt = burst_len(own_burst[2:0]);
         else if (own_trans == HT_SEQ &&
                  cnt != 5'd0)
            cnt_nxt = cnt - 5'd1;
      end
   end

   // Next state, grant and owner.
   always_comb begin
      state_nxt  = state;
      grant_nxt  = hgrant_o;
      master_nxt = hmaster_o;
      if (hready_i) begin
         if (handover) begin
            master_nxt = gnt_idx;
            if (hlock_i[gnt_idx])
               state_nxt = ARB_LOCKED;
         end else if (state == ARB_LOCKED) begin
            if (!own_lock)
               state_nxt = ARB_OWNED;
         end else if (own_lock) begin
            state_nxt = ARB_LOCKED;
         end else if (boundary) begin
            if (|hbusreq_i) begin
               grant_nxt = rr_gnt;
               state_nxt = ARB_OWNED;
            end else begin
               grant_nxt = PARK;
               state_nxt = ARB_IDLE;
            end
         end else if (own_trans[1]) begin
            state_nxt = ARB_OWNED;
         end
      end
   end

   // Arbiter registers; all hold on wait states.
   always_ff @(posedge hclk_i or posedge hrst_i) begin
      if (hrst_i) begin
         state     <= ARB_IDLE;
         hgrant_o  <= PARK;
         hmaster_o <= '0;
         downer    <= '0;
         cnt       <= 5'd0;
      end else begin
         state     <= state_nxt;
         hgrant_o  <= grant_nxt;
         hmaster_o <= master_nxt;
         cnt       <= cnt_nxt;
         if (hready_i) downer <= hmaster_o;
      end
   end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter with a
// queue scoreboard sampled on the falling edge.
module tb_ahb_arbiter;
   import ahb_pkg::*;

   typedef struct packed {
      logic [1:0]  gnt;
      logic        mst;
      logic        lock;
      logic [31:0] addr;
      logic [1:0]  trans;
      logic [2:0]  burst;
      logic [31:0] wdata;
   } exp_t;

   logic        hclk = 1'b0;
   logic        hrst = 1'b1;
   logic        rdy  = 1'b1;
   logic [1:0]  req  = 2'b00;
   logic [1:0]  lock = 2'b00;
   logic [1:0]  tr [2];
   logic [2:0]  bu [2];
   logic [31:0] ad [2];
   logic [31:0] wd [2];

   logic [1:0]  hgrant;
   logic        hmaster;
   logic        hmastlock;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic [2:0]  hburst;
   logic [2:0]  hsize;
   logic        hwrite;
   logic [31:0] hwdata;

   exp_t  sb [$];
   string nq [$];
   int    n_chk = 0;
   int    n_err = 0;

   always #5 hclk = ~hclk;

   ahb_arbiter #(
      .NUM_MST      (2),
      .ADDR_WIDTH   (32),
      .DATA_WIDTH   (32),
      .HBURST_WIDTH (3)
   ) dut (
      .hclk_i      (hclk),
      .hrst_i      (hrst),
      .hbusreq_i   (req),
      .hlock_i     (lock),
      .haddr_m_i   ({ad[1], ad[0]}),
      .htrans_m_i  ({tr[1], tr[0]}),
      .hburst_m_i  ({bu[1], bu[0]}),
      .hsize_m_i   ({3'd2, 3'd2}),
      .hwrite_m_i  (2'b11),
      .hwdata_m_i  ({wd[1], wd[0]}),
      .hready_i    (rdy),
      .hgrant_o    (hgrant),
      .hmaster_o   (hmaster),
      .hmastlock_o (hmastlock),
      .haddr_o     (haddr),
      .htrans_o    (htrans),
      .hburst_o    (hburst),
      .hsize_o     (hsize),
      .hwrite_o    (hwrite),
      .hwdata_o    (hwdata)
   );

   task automatic m(input int k,
                    input logic [1:0] t,
                    input logic [2:0] b,
                    input logic [31:0] a);
      tr[k] = t;
      bu[k] = b;
      ad[k] = a;
      wd[k] = a ^ 32'h5A5A_0F0F;
   endtask

   task automatic idle(input int k);
      tr[k] = HT_IDLE;
   endtask

   // Push the hand-derived expectation for the
   // current cycle, then move to the next one.
   task automatic step(input string nm,
                       input logic [1:0] g,
                       input logic ms,
                       input logic dw,
                       input logic lk);
      exp_t e;
      e.gnt   = g;
      e.mst   = ms;
      e.lock  = lk;
      e.addr  = ad[ms];
      e.trans = tr[ms];
      e.burst = bu[ms];
      e.wdata = wd[dw];
      sb.push_back(e);
      nq.push_back(nm);
      @(posedge hclk);
      #1;
   endtask

   task automatic chk(input string nm,
                      input string f,
                      input logic [31:0] a,
                      input logic [31:0] x);
      n_chk++;
      if (a !== x) begin
         n_err++;
         $display("FAIL %s.%s: got %h expected %h",
                  nm, f, a, x);
      end
   endtask

   // Monitor: compare outputs each cycle.
   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(negedge hclk);
         if (sb.size() != 0) begin
            e  = sb.pop_front();
            nm = nq.pop_front();
            chk(nm, "gnt",   32'(hgrant),    32'(e.gnt));
            chk(nm, "mst",   32'(hmaster),   32'(e.mst));
            chk(nm, "lock",  32'(hmastlock), 32'(e.lock));
            chk(nm, "addr",  haddr,          e.addr);
            chk(nm, "trans", 32'(htrans),    32'(e.trans));
            chk(nm, "burst", 32'(hburst),    32'(e.burst));
            chk(nm, "wdata", hwdata,         e.wdata);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: no finish by time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      m(0, HT_IDLE, HB_SINGLE, 32'hA000_0000);
      m(1, HT_IDLE, HB_SINGLE, 32'h0000_0010);
      repeat (2) @(posedge hclk);
      #1;
      step("R0", 2'b01, 0, 0, 0);
      hrst = 1'b0;

      req = 2'b10;
      step("A1", 2'b01, 0, 0, 0);
      step("A2", 2'b10, 0, 0, 0);
      m(1, HT_NONSEQ, HB_INCR4, 32'h24);
      req = 2'b00;
      step("A3", 2'b10, 1, 0, 0);
      m(1, HT_SEQ, HB_INCR4, 32'h28);
      step("A4", 2'b10, 1, 1, 0);
      m(1, HT_SEQ, HB_INCR4, 32'h2C);
      step("A5", 2'b10, 1, 1, 0);
      m(1, HT_SEQ, HB_INCR4, 32'h30);
      step("A6", 2'b10, 1, 1, 0);
      idle(1);
      step("A7", 2'b01, 1, 1, 0);
      step("A8", 2'b01, 0, 1, 0);
      step("A9", 2'b01, 0, 0, 0);

      req = 2'b01;
      step("B1", 2'b01, 0, 0, 0);
      req = 2'b11;
      m(0, HT_NONSEQ, HB_WRAP8, 32'hA000_0040);
      step("B2", 2'b01, 0, 0, 0);
      for (int i = 1; i <= 7; i++) begin
         m(0, HT_SEQ, HB_WRAP8,
           32'hA000_0040 + 32'(4 * i));
         step("B_m0", 2'b01, 0, 0, 0);
      end
      idle(0);
      step("B10", 2'b10, 0, 0, 0);
      m(1, HT_NONSEQ, HB_WRAP8, 32'h200);
      step("B11", 2'b10, 1, 0, 0);
      for (int i = 1; i <= 7; i++) begin
         m(1, HT_SEQ, HB_WRAP8,
           32'h200 + 32'(4 * i));
         step("B_m1", 2'b10, 1, 1, 0);
      end
      idle(1);
      step("B19", 2'b01, 1, 1, 0);
      req = 2'b00;
      step("B20", 2'b01, 0, 1, 0);
      step("B21", 2'b01, 0, 0, 0);

      req  = 2'b11;
      lock = 2'b01;
      step("C1", 2'b01, 0, 0, 0);
      m(0, HT_NONSEQ, HB_SINGLE, 32'hA000_0100);
      step("C2", 2'b01, 0, 0, 1);
      m(0, HT_NONSEQ, HB_SINGLE, 32'hA000_0104);
      step("C3", 2'b01, 0, 0, 1);
      m(0, HT_NONSEQ, HB_SINGLE, 32'hA000_0108);
      lock = 2'b00;
      req  = 2'b10;
      step("C4", 2'b01, 0, 0, 1);
      idle(0);
      step("C5", 2'b01, 0, 0, 0);
      step("C6", 2'b10, 0, 0, 0);
      m(1, HT_NONSEQ, HB_SINGLE, 32'h300);
      req = 2'b00;
      step("C7", 2'b10, 1, 0, 0);
      idle(1);
      step("C8", 2'b01, 1, 1, 0);
      step("C9", 2'b01, 0, 1, 0);
      step("C10", 2'b01, 0, 0, 0);

      req = 2'b10;
      step("D1", 2'b01, 0, 0, 0);
      step("D2", 2'b10, 0, 0, 0);
      m(1, HT_NONSEQ, HB_INCR4, 32'h100);
      req = 2'b00;
      step("D3", 2'b10, 1, 0, 0);
      m(1, HT_SEQ, HB_INCR4, 32'h104);
      step("D4", 2'b10, 1, 1, 0);
      m(1, HT_SEQ, HB_INCR4, 32'h108);
      req = 2'b01;
      rdy = 1'b0;
      for (int i = 0; i < 5; i++)
         step("D_wait", 2'b10, 1, 1, 0);
      rdy = 1'b1;
      step("D10", 2'b10, 1, 1, 0);
      m(1, HT_SEQ, HB_INCR4, 32'h10C);
      step("D11", 2'b10, 1, 1, 0);
      idle(1);
      step("D12", 2'b01, 1, 1, 0);
      req = 2'b00;
      step("D13", 2'b01, 0, 1, 0);
      step("D14", 2'b01, 0, 0, 0);

      req = 2'b10;
      step("E1", 2'b01, 0, 0, 0);
      step("E2", 2'b10, 0, 0, 0);
      m(1, HT_NONSEQ, HB_INCR16, 32'h400);
      req = 2'b00;
      step("E3", 2'b10, 1, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         m(1, HT_SEQ, HB_INCR16,
           32'h400 + 32'(4 * i));
         step("E_beat", 2'b10, 1, 1, 0);
      end
      m(1, HT_SEQ, HB_INCR16, 32'h414);
      hrst = 1'b1;
      step("E8", 2'b01, 0, 0, 0);
      idle(1);
      req = 2'b10;
      step("E9", 2'b01, 0, 0, 0);
      hrst = 1'b0;
      step("E10", 2'b01, 0, 0, 0);
      step("E11", 2'b10, 0, 0, 0);
      m(1, HT_NONSEQ, HB_SINGLE, 32'h500);
      req = 2'b00;
      step("E12", 2'b10, 1, 0, 0);
      idle(1);
      step("E13", 2'b01, 1, 1, 0);
      step("E14", 2'b01, 0, 1, 0);
      step("E15", 2'b01, 0, 0, 0);

      for (int i = 0; i < 10 && sb.size() != 0; i++)
         @(negedge hclk);
      #1;
      n_chk++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d left, expected 0",
                  sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 Parameter NUM_MST, default 2: number of AHB requesters, legal 2..4.
REQ-002 Parameter ADDR_WIDTH, default 32: address width.
REQ-003 Parameter DATA_WIDTH, default 32: write data width.
REQ-004 Parameter HBURST_WIDTH, default 3: hburst width.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 hclk_i  in  1  AHB clock; all state on its rising edge.
REQ-007 hrst_i  in  1  asynchronous active-high reset.
REQ-008 hbusreq_i  in  NUM_MST  per-master bus request.
REQ-009 hlock_i  in  NUM_MST  per-master locked-transfer request.
REQ-010 haddr_m_i  in  NUM_MST*ADDR_WIDTH  flattened master addresses; master k in slice k.
REQ-011 htrans_m_i  in  NUM_MST*2  flattened transfer types.
REQ-012 hburst_m_i  in  NUM_MST*HBURST_WIDTH  flattened burst types.
REQ-013 hsize_m_i  in  NUM_MST*3  flattened sizes.
REQ-014 hwrite_m_i  in  NUM_MST  per-master write flag.
REQ-015 hwdata_m_i  in  NUM_MST*DATA_WIDTH  flattened write data.
REQ-016 hready_i  in  1  transfer-done from the ahb2apb bridge (its hready_o).
REQ-017 hgrant_o  out  NUM_MST  one-hot grant.
REQ-018 hmaster_o  out  $clog2(NUM_MST)  address-phase owner index.
REQ-019 hmastlock_o  out  1  current address phase is locked.
REQ-020 haddr_o/htrans_o/hburst_o/hsize_o/hwrite_o  out  muxed address/control to bridge.
REQ-021 hwdata_o  out  DATA_WIDTH  write data muxed by data-phase owner.

Function
REQ-022 FSM states ARB_IDLE (parked, no owner active), ARB_OWNED (owner issuing), ARB_LOCKED (owner holds lock).
REQ-023 All state, grant, counter and owner registers hold while hready_i=0.
REQ-024 Arbitration only in a cycle with hready_i=1 and at a boundary: owner htrans IDLE, owner hbusreq_i=0 during INCR/SINGLE, or fixed burst with beat counter 0 on an accepted SEQ/NONSEQ.
REQ-025 Arbitration is round-robin: search starts at (hmaster_o+1) mod NUM_MST; the first requester wins.
REQ-026 No requester at a boundary: grant parks on master 0; state ARB_IDLE; htrans_o reflects master 0 (expected IDLE).
REQ-027 hgrant_o updates at the arbitration edge; hmaster_o takes the granted index on the next hready_i=1 edge (grant precedes ownership by one accepted cycle).
REQ-028 Address mux outputs are combinational from hmaster_o slices.
REQ-029 Data owner register takes hmaster_o on each hready_i=1 edge; hwdata_o selects that slice (one-beat pipeline).
REQ-030 Beat counter 5 bits: on accepted NONSEQ load 3/7/15 for WRAP4/INCR4, WRAP8/INCR8, WRAP16/INCR16, 0 otherwise; decrement on accepted SEQ; BUSY holds it.
REQ-031 Owner with hlock_i=1 enters ARB_LOCKED; no re-arbitration until hlock_i falls and one further accepted transfer completes; hmastlock_o = owner hlock in address phase.
REQ-032 Simultaneous requests from all masters with owner releasing: next-index master wins; the released owner is lowest priority.
REQ-033 A request withdrawn mid fixed-length burst does not end the burst early; grant kept until counter 0.

Reset
REQ-034 During hrst_i: hgrant_o=1 at bit0, hmaster_o=0, data owner=0, counter=0, hmastlock_o=0, state ARB_IDLE; muxed outputs follow master 0.
REQ-035 Reset asserted mid-burst aborts immediately (asynchronous); after release arbitration restarts from ARB_IDLE.

Structure
REQ-036 Shared package ahb_pkg holds HTRANS/HBURST encodings, arbiter state enum and burst-length function.
REQ-037 One sub-module, rr_arbiter (NUM_MST requests, pointer in, one-hot grant out), combinational.

Verification
REQ-038 Single master 1 request, INCR4 at 0x24 -> hgrant_o=2'b10, hmaster_o=1 one accepted cycle later, 4 beats passed, then park on 0.
REQ-039 Both masters request continuously, WRAP8 each -> grants alternate 0,1,0 only after 8th beat; no mid-burst switch.
REQ-040 Master 0 locked, master 1 requesting -> master 1 granted only one transfer after hlock_i[0] falls; hmastlock_o=1 meanwhile.
REQ-041 hready_i held 0 for 5 cycles mid-burst -> grant, hmaster_o, counter, hwdata_o unchanged.
REQ-042 hrst_i pulsed during INCR16 beat 6 -> outputs at reset values same cycle; fresh arbitration afterwards.
REQ-043 Write burst with owner change -> hwdata_o follows data-phase owner, lagging hmaster_o by one accepted cycle.
